// File: rtl/reg_access_pkg.sv
// Shared types for the register-file access controller: FSM states, width defaults, response record.
// REG_ACCESS_VERIFY_EN adds the write read-back state WR_VFY.
package reg_access_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_HOLD,
    ST_WR,
`ifdef REG_ACCESS_VERIFY_EN
    ST_WR_VFY,
`endif
    ST_WR_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Host command/write-data/response channels plus the register-file port of reg_access_ctrl.
interface reg_access_ctrl_if
  import reg_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready, rf_rdata,
    output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           rf_we, rf_waddr, rf_wdata, rf_raddr
  );

  // Host plus register file side.
  modport master (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready, rf_rdata,
    input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           rf_we, rf_waddr, rf_wdata, rf_raddr
  );
endinterface

// File: rtl/reg_access_beat_ctr.sv
// Burst address/beat counter: loads start index and length, then steps the index with wrap.
module reg_access_beat_ctr
  import reg_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] beats_left,
  output logic              is_last
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      beats_left <= '0;
    end else if (load) begin
      addr       <= load_addr;
      beats_left <= load_len;
    end else if (advance) begin
      // Index wraps modulo 2**ADDR_W through natural overflow.
      addr       <= addr + 1'b1;
      beats_left <= beats_left - 1'b1;
    end
  end

  assign is_last = (beats_left == '0);

endmodule

// File: rtl/reg_access_ctrl.sv
// Host-side initiator sequencing single/burst reads and writes onto the register file ports.
// Define REG_ACCESS_VERIFY_EN to read back and compare each nonzero-index write beat.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  reg_access_ctrl_if.slave   bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;
  logic              is_last;
  logic              ctr_load;
  logic              ctr_advance;
  logic              addr_zero;
  logic [DATA_W-1:0] rd_data_q;
  logic              err_q;
  rsp_t              rsp;
`ifdef REG_ACCESS_VERIFY_EN
  logic [DATA_W-1:0] vfy_data_q;
`endif

  assign addr_zero = (cur_addr == '0);

  reg_access_beat_ctr #(.ADDR_W(ADDR_W)) u_beat_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .load_addr  (bus.req_addr),
    .load_len   (bus.req_len),
    .advance    (ctr_advance),
    .addr       (cur_addr),
    .beats_left (beats_left),
    .is_last    (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // err_q is per-beat on reads and sticky across a write burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.req_valid) err_q <= 1'b0;
        ST_RD: begin
          rd_data_q <= addr_zero ? '0 : bus.rf_rdata;
          err_q     <= addr_zero;
        end
        ST_WR:      if (bus.wdata_valid && addr_zero) err_q <= 1'b1;
`ifdef REG_ACCESS_VERIFY_EN
        ST_WR_VFY:  if (bus.rf_rdata != vfy_data_q) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef REG_ACCESS_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst)                                         vfy_data_q <= '0;
    else if (state_q == ST_WR && bus.wdata_valid)    vfy_data_q <= bus.wdata;
  end
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d         = state_q;
    ctr_load        = 1'b0;
    ctr_advance     = 1'b0;
    rsp             = '0;
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = cur_addr;
    bus.rf_wdata    = bus.wdata;
    bus.rf_raddr    = cur_addr;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          ctr_load = 1'b1;
          state_d  = bus.req_write ? ST_WR : ST_RD;
        end
      end
      ST_RD: state_d = ST_RD_HOLD;
      ST_RD_HOLD: begin
        bus.rsp_valid = 1'b1;
        rsp.data      = DATA_W_DEF'(rd_data_q);
        rsp.last      = (beats_left == '0);
        rsp.err       = err_q;
        if (bus.rsp_ready) begin
          if (is_last) state_d = ST_IDLE;
          else begin
            ctr_advance = 1'b1;
            state_d     = ST_RD;
          end
        end
      end
      ST_WR: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          bus.rf_we = 1'b1;
`ifdef REG_ACCESS_VERIFY_EN
          // The index holds still through WR_VFY so rf_raddr points at the beat just written.
          if (!addr_zero)   state_d = ST_WR_VFY;
          else if (is_last) state_d = ST_WR_RESP;
          else              ctr_advance = 1'b1;
`else
          if (is_last) state_d = ST_WR_RESP;
          else         ctr_advance = 1'b1;
`endif
        end
      end
`ifdef REG_ACCESS_VERIFY_EN
      ST_WR_VFY: begin
        if (is_last) state_d = ST_WR_RESP;
        else begin
          ctr_advance = 1'b1;
          state_d     = ST_WR;
        end
      end
`endif
      ST_WR_RESP: begin
        bus.rsp_valid = 1'b1;
        rsp.last      = 1'b1;
        rsp.err       = err_q;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bus.rsp_data = DATA_W'(rsp.data);
    bus.rsp_last = rsp.last;
    bus.rsp_err  = rsp.err;

    // Outputs are forced quiet in the reset cycle itself, not just after it.
    if (rst) begin
      bus.req_ready   = 1'b0;
      bus.wdata_ready = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.rsp_data    = '0;
      bus.rsp_last    = 1'b0;
      bus.rsp_err     = 1'b0;
      bus.rf_we       = 1'b0;
      bus.rf_waddr    = '0;
      bus.rf_wdata    = '0;
      bus.rf_raddr    = '0;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: directed bursts, expected responses and writes queued at issue.
module tb_reg_access_ctrl;
  import reg_access_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_ACCESS_VERIFY_EN
  localparam int BEAT_GAP = 2;
`else
  localparam int BEAT_GAP = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } exp_rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_rsp_t      rsp_exp[$];
  exp_wr_t       wr_exp[$];
  int            we_cyc[$];
  int            rsp_cyc[$];
  logic [DW-1:0] beats[$];
  int            cyc   = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic          force_mm = 1'b0;
  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: index 0 reads 0 and ignores writes; reset presets 0x1000_0000 | index.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 32'h1000_0000 | i;
    end else if (bus.rf_we && bus.rf_waddr != '0) begin
      mem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  assign bus.rf_rdata = (bus.rf_raddr == '0) ? '0 : (mem[bus.rf_raddr] ^ {31'b0, force_mm});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Monitors: compare every response handshake and every register-file write against the queues.
  always @(negedge clk) begin
    exp_rsp_t er;
    exp_wr_t  ew;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (rsp_exp.size() == 0) fail("rsp_unexpected");
      else begin
        er = rsp_exp.pop_front();
        check("rsp_data", bus.rsp_data, er.data);
        check("rsp_last", bus.rsp_last, er.last);
        check("rsp_err",  bus.rsp_err,  er.err);
      end
      rsp_cyc.push_back(cyc);
    end
    if (bus.rf_we) begin
      if (wr_exp.size() == 0) fail("rf_we_unexpected");
      else begin
        ew = wr_exp.pop_front();
        check("rf_waddr", bus.rf_waddr, ew.addr);
        check("rf_wdata", bus.rf_wdata, ew.data);
      end
      we_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l,
                        output int acc);
    bit seen = 0;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        seen = 1;
        acc  = cyc;
      end
      tick();
      if (seen) break;
    end
    bus.req_valid = 1'b0;
    if (!seen) fail("req_accept_timeout");
  endtask

  task automatic send_beats();
    bus.wdata_valid = 1'b1;
    foreach (beats[k]) begin
      bit ok = 0;
      bus.wdata = beats[k];
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.wdata_ready) ok = 1;
        tick();
        if (ok) break;
      end
      if (!ok) fail("wdata_timeout");
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (rsp_exp.size() != 0 || wr_exp.size() != 0); i++) tick();
    if (rsp_exp.size() != 0 || wr_exp.size() != 0) fail("drain_timeout");
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl_bits"}, {bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_err,
                                bus.wdata_ready, bus.rf_we}, 6'b0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rf_waddr"}, bus.rf_waddr, 0);
    check({tag, "_rf_raddr"}, bus.rf_raddr, 0);
    check({tag, "_rf_wdata"}, bus.rf_wdata, 0);
  endtask

  initial begin
    int acc;
    bit seen;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rsp_ready   = 1'b1;
    rst             = 1'b1;

    // Reset state
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", bus.req_ready, 1);
    tick();

    // Write burst 3..5, wdata_valid held high
    we_cyc.delete();
    rsp_cyc.delete();
    wr_exp.push_back('{5'd3, 32'hA});
    wr_exp.push_back('{5'd4, 32'hB});
    wr_exp.push_back('{5'd5, 32'hC});
    rsp_exp.push_back('{32'h0, 1'b1, 1'b0});
    beats = '{32'hA, 32'hB, 32'hC};
    do_req(1'b1, 5'd3, 5'd2, acc);
    send_beats();
    drain();
    check("wr_beat_count", we_cyc.size(), 3);
    check("wr_first_beat_lat", we_cyc[0] - acc, 1);
    check("wr_beat_gap_1", we_cyc[1] - we_cyc[0], BEAT_GAP);
    check("wr_beat_gap_2", we_cyc[2] - we_cyc[1], BEAT_GAP);
    check("wr_cpl_lat", rsp_cyc[0] - we_cyc[2], BEAT_GAP);

    // Read back 3..5 with rsp_ready high: data at T+2, T+4, T+6
    rsp_cyc.delete();
    rsp_exp.push_back('{32'hA, 1'b0, 1'b0});
    rsp_exp.push_back('{32'hB, 1'b0, 1'b0});
    rsp_exp.push_back('{32'hC, 1'b1, 1'b0});
    do_req(1'b0, 5'd3, 5'd2, acc);
    drain();
    check("rd_lat_beat0", rsp_cyc[0] - acc, 2);
    check("rd_lat_beat1", rsp_cyc[1] - acc, 4);
    check("rd_lat_beat2", rsp_cyc[2] - acc, 6);

    // Read 30,31,0,1 across the wrap; index 0 returns 0 with err
    rsp_exp.push_back('{32'h1000_001E, 1'b0, 1'b0});
    rsp_exp.push_back('{32'h1000_001F, 1'b0, 1'b0});
    rsp_exp.push_back('{32'h0,         1'b0, 1'b1});
    rsp_exp.push_back('{32'h1000_0001, 1'b1, 1'b0});
    do_req(1'b0, 5'd30, 5'd3, acc);
    drain();

    // Single write to index 0: write pulses, completion flags err
    wr_exp.push_back('{5'd0, 32'hFFFF});
    rsp_exp.push_back('{32'h0, 1'b1, 1'b1});
    beats = '{32'hFFFF};
    do_req(1'b1, 5'd0, 5'd0, acc);
    send_beats();
    drain();

    // Backpressure: rsp_ready low for 5 cycles holds the first read beat
    bus.rsp_ready = 1'b0;
    rsp_exp.push_back('{32'hA, 1'b0, 1'b0});
    rsp_exp.push_back('{32'hB, 1'b1, 1'b0});
    do_req(1'b0, 5'd3, 5'd1, acc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("hold_rsp_valid_timeout");
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_data",  bus.rsp_data, 32'hA);
      check("hold_rsp_last",  bus.rsp_last, 0);
      check("hold_rf_raddr",  bus.rf_raddr, 3);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset during the second beat of a 4-beat write
    wr_exp.push_back('{5'd8, 32'hD1});
    do_req(1'b1, 5'd8, 5'd3, acc);
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'hD1;
    @(negedge clk);
    check("midrst_beat1_ready", bus.wdata_ready, 1);
    tick();
    bus.wdata = 32'hD2;
    rst       = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst             = 1'b0;
    bus.wdata_valid = 1'b0;
    @(negedge clk);
    check("midrst_req_ready_next", bus.req_ready, 1);
    check("midrst_wr_pending", wr_exp.size(), 0);
    tick();

`ifdef REG_ACCESS_VERIFY_EN
    // Read-back mismatch on a write to index 7
    wr_exp.push_back('{5'd7, 32'h77});
    rsp_exp.push_back('{32'h0, 1'b1, 1'b1});
    do_req(1'b1, 5'd7, 5'd0, acc);
    force_mm        = 1'b1;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'h77;
    @(negedge clk);
    check("vfy_beat_ready", bus.wdata_ready, 1);
    tick();
    @(negedge clk);
    check("vfy_wdata_ready_low", bus.wdata_ready, 0);
    check("vfy_rf_raddr", bus.rf_raddr, 7);
    tick();
    bus.wdata_valid = 1'b0;
    drain();
    force_mm = 1'b0;
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Host-side initiator for the 32×32 integer register file. It accepts single or burst read/write commands over a valid/ready request channel and sequences them onto the file's write port and one read port. It returns per-beat read data and a single write completion over a valid/ready response channel. It sits between the debug/test host interface and the register file, and shares the file's ports through the core's debug mux.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width; the file holds 2**ADDR_W entries

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  controller can accept a command
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  first register index
- req_len  in  ADDR_W  beat count minus 1 (0 = one beat, 31 = 32 beats)
- wdata_valid  in  1  write beat data present
- wdata_ready  out  1  controller consumes a write beat
- wdata  in  DATA_W  write beat data
- rsp_valid  out  1  response present
- rsp_ready  in  1  host takes the response
- rsp_data  out  DATA_W  read data; 0 for the write completion
- rsp_last  out  1  final response of the burst
- rsp_err  out  1  error flag, defined under Operation
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- rf_raddr  out  ADDR_W  register file read index
- rf_rdata  in  DATA_W  register file read data (combinational from rf_raddr)

## Operation
States: IDLE, RD, RD_HOLD, WR, WR_VFY (only with the macro), WR_RESP.

- IDLE
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, len and write; clear the error flag.
  - Go to WR if write, else RD.
- RD
  - rf_raddr=cur_addr.
  - Capture rf_rdata into rsp_data.
  - Set rsp_err=1 if cur_addr==0; the read still completes and returns 0.
  - Go to RD_HOLD.
- RD_HOLD
  - rsp_valid=1 and rsp_last=(beats_left==0).
  - rsp_data, rsp_last and rsp_err stay stable until rsp_ready.
  - On the handshake, if beats remain: increment the address and go to RD; otherwise go to IDLE.
- WR
  - wdata_ready=1.
  - On a wdata handshake, in the same cycle: rf_we=1, rf_waddr=cur_addr, rf_wdata=wdata.
  - A beat to index 0 sets the sticky error; the file discards the write.
  - Decrement beats and increment the address. The last beat goes to WR_RESP.
- WR_RESP
  - rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=sticky error.
  - Hold until rsp_ready, then go to IDLE.
- Address arithmetic is modulo 2**ADDR_W: 31 increments to 0, and no error is raised for the wrap itself. A wrapped beat that lands on index 0 flags rsp_err like any other beat to index 0.
- rf_we=0 in every state except WR during a handshake cycle.
- rf_raddr=cur_addr in all states.

## Timing
- Reset: state=IDLE; req_ready=0 during the reset cycle and 1 from the next cycle. Outputs in reset:
  - rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0
  - wdata_ready=0, rf_we=0
  - rf_waddr=0, rf_raddr=0, rf_wdata=0
- Reset mid-burst aborts the burst: any pending response is dropped, and no rf_we is asserted in the reset cycle.
- Read latency: request accepted in cycle T, RD in T+1, rsp_valid in T+2. Peak throughput is one beat per 2 cycles with rsp_ready held high.
- Write: request accepted in T, wdata_ready from T+1. Without the macro, one beat per cycle. The completion response appears in the cycle after the last beat.
- A new request is accepted only in IDLE, so a request and a response handshake never coincide.

## Configuration
- REG_ACCESS_VERIFY_EN defined:
  - Each accepted write beat to a nonzero index enters WR_VFY for one cycle.
  - In WR_VFY: wdata_ready=0, rf_raddr=the just-written index, and rf_rdata is compared with the latched beat data.
  - A mismatch sets the sticky error.
  - Beats to index 0 skip WR_VFY.
  - Write throughput drops to one beat per 2 cycles.
- Not defined: no WR_VFY state, no comparator logic, and rsp_err on writes reflects only index-0 beats.

## Structure
- Shared package reg_access_pkg:
  - state enum
  - DATA_W and ADDR_W defaults
  - response record (data, last, err)
- One sub-module, reg_access_beat_ctr: loads addr/len, then provides increment-with-wrap, beats_left and an is_last output.
- The FSM and output muxing stay in the top module.

## Test plan
- Write burst addr=3, len=2, data 0xA, 0xB, 0xC with wdata_valid held high. Required:
  - rf_we on 3 consecutive cycles to indices 3, 4, 5
  - one completion with rsp_last=1, rsp_err=0
- Read burst addr=3, len=2 after that write, rsp_ready=1. Required: rsp_data 0xA, 0xB, 0xC at T+2, T+4, T+6, with rsp_last only on 0xC.
- Read addr=30, len=3. Required:
  - indices 30, 31, 0, 1
  - the index-0 beat returns 0 with rsp_err=1
  - the other beats have rsp_err=0
- Write addr=0, len=0, data 0xFFFF. Required: rf_we pulses at index 0, and the completion has rsp_err=1.
- rsp_ready held low for 5 cycles during a read. Required: rsp_valid, rsp_data and rsp_last stable, and no new rf_raddr advance.
- rst asserted in the cycle of the second beat of a 4-beat write. Required:
  - no rf_we in that cycle
  - all outputs at their reset values
  - req_ready=1 on the following cycle
- With REG_ACCESS_VERIFY_EN defined, force rf_rdata to mismatch on a write to index 7. Required:
  - wdata_ready=0 for one cycle after the beat
  - completion rsp_err=1
